// File: rtl/demux2_buffered_if.sv
// Handshake bundle for demux2_buffered: one producer side and two independent consumer sides.
// The slave modport is the demux's view; master is the surrounding producer/consumer view.
interface demux2_buffered_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic             in_select;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic [CW-1:0]    out0_count;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CW-1:0]    out1_count;

    modport slave (
        input  in_valid, in_select, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_count,
               out1_valid, out1_data, out1_count
    );

    modport master (
        output in_valid, in_select, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_count,
               out1_valid, out1_data, out1_count
    );
endinterface

// File: rtl/demux2_buffered.sv
// Buffered 1-to-2 demultiplexer: each accepted beat is steered by in_select into one of two
// independent DEPTH-entry FIFOs, so a stalled consumer never blocks the other destination.
module demux2_buffered #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    demux2_buffered_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        EMPTY    = 1'b0,
        NONEMPTY = 1'b1
    } fifoState_e;

    fifoState_e       state_q [2];
    fifoState_e       state_d [2];
    logic [WIDTH-1:0] mem_q   [2][DEPTH];
    logic [PW-1:0]    wrPtr_q [2];
    logic [PW-1:0]    wrPtr_d [2];
    logic [PW-1:0]    rdPtr_q [2];
    logic [PW-1:0]    rdPtr_d [2];
    logic [CW-1:0]    count_q [2];
    logic [CW-1:0]    count_d [2];

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] outReady;

    assign outReady = {bus.out1_ready, bus.out0_ready};

    // Fullness comes only from registered counts, keeping out*_ready off the in_ready path.
    always_comb begin
        full = '0;
        for (int k = 0; k < 2; k++) begin
            full[k] = (count_q[k] == CW'(DEPTH));
        end
    end

    assign bus.in_ready = ~full[bus.in_select];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < 2; k++) begin
            wrPtr_d[k] = wrPtr_q[k];
            rdPtr_d[k] = rdPtr_q[k];
            count_d[k] = count_q[k];
            state_d[k] = state_q[k];

            push[k] = bus.in_valid && !full[k] && (bus.in_select == 1'(k));
            pop[k]  = outReady[k] && (state_q[k] == NONEMPTY);

            if (push[k]) begin
                wrPtr_d[k] = wrPtr_q[k] + PW'(1);
            end
            if (pop[k]) begin
                rdPtr_d[k] = rdPtr_q[k] + PW'(1);
            end

            case ({push[k], pop[k]})
                2'b10:   count_d[k] = count_q[k] + CW'(1);
                2'b01:   count_d[k] = count_q[k] - CW'(1);
                default: count_d[k] = count_q[k];
            endcase

            case (state_q[k])
                EMPTY: begin
                    if (push[k]) begin
                        state_d[k] = NONEMPTY;
                    end
                end
                NONEMPTY: begin
                    if (pop[k] && !push[k] && (count_q[k] == CW'(1))) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= EMPTY;
                wrPtr_q[k] <= '0;
                rdPtr_q[k] <= '0;
                count_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                wrPtr_q[k] <= wrPtr_d[k];
                rdPtr_q[k] <= rdPtr_d[k];
                count_q[k] <= count_d[k];
            end
        end
    end

    // Storage is cleared on reset so an empty FIFO presents zero data rather than stale beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[k][d] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem_q[k][wrPtr_q[k]] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out0_valid = (state_q[0] == NONEMPTY);
    assign bus.out1_valid = (state_q[1] == NONEMPTY);
    assign bus.out0_data  = mem_q[0][rdPtr_q[0]];
    assign bus.out1_data  = mem_q[1][rdPtr_q[1]];
    assign bus.out0_count = count_q[0];
    assign bus.out1_count = count_q[1];
endmodule

// File: tb/tb_demux2_buffered.sv
// Scoreboard bench for demux2_buffered: accepted beats are queued per destination and a
// negedge monitor compares occupancy, valid, in_ready and popped data against those queues.
module tb_demux2_buffered;
    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux2_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH-1:0] exp0[$];
    logic [WIDTH-1:0] exp1[$];
    int checks    = 0;
    int failures  = 0;
    bit monitorOn = 1'b0;
    int readyMode = 0;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Readies are only changed just after a rising edge, so they are stable at every sample.
    task automatic tick();
        @(posedge clk);
        #1;
        case (readyMode)
            1: begin
                bus.out0_ready = 1'($urandom_range(1));
                bus.out1_ready = 1'($urandom_range(1));
            end
            2: begin
                bus.out0_ready = 1'b1;
                bus.out1_ready = ~bus.out1_ready;
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic sel, input logic [WIDTH-1:0] data, output int waited);
        bit accepted = 1'b0;
        waited = 0;
        bus.in_valid  = 1'b1;
        bus.in_select = sel;
        bus.in_data   = data;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            tick();
            waited = c + 1;
            if (accepted) begin
                if (sel) exp1.push_back(data);
                else     exp0.push_back(data);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!accepted) begin
            failures++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept of %h", data);
        end
    endtask

    task automatic drain();
        readyMode      = 0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        for (int c = 0; c < 50 && (exp0.size() != 0 || exp1.size() != 0); c++) begin
            tick();
        end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", exp0.size(), exp1.size());
        end
    endtask

    task automatic doReset();
        monitorOn     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_select = 1'b0;
        bus.in_data   = 64'hDEAD_BEEF_0BAD_F00D;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        checkOutput("rst_valid0", bus.out0_valid, 1'b0);
        checkOutput("rst_valid1", bus.out1_valid, 1'b0);
        checkOutput("rst_count0", bus.out0_count, 0);
        checkOutput("rst_count1", bus.out1_count, 0);
        checkOutput("rst_data0", bus.out0_data, 0);
        checkOutput("rst_data1", bus.out1_data, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1'b1);
        monitorOn = 1'b1;
        tick();
    endtask

    // Monitor: occupancy equals outstanding expected beats; a pop must match the queue head.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("count0", bus.out0_count, exp0.size());
            checkOutput("count1", bus.out1_count, exp1.size());
            checkOutput("valid0", bus.out0_valid, exp0.size() != 0);
            checkOutput("valid1", bus.out1_valid, exp1.size() != 0);
            checkOutput("in_ready", bus.in_ready,
                        (bus.in_select ? exp1.size() : exp0.size()) != DEPTH);
            if (bus.out0_valid && bus.out0_ready && exp0.size() != 0) begin
                checkOutput("data0", bus.out0_data, exp0.pop_front());
            end
            if (bus.out1_valid && bus.out1_ready && exp1.size() != 0) begin
                checkOutput("data1", bus.out1_data, exp1.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_select  = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        doReset();

        // Steering with both consumers ready.
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        applyStimulus(1'b0, 64'hA5A5, waited);
        @(negedge clk);
        checkOutput("steer0_valid", bus.out0_valid, 1'b1);
        checkOutput("steer0_data", bus.out0_data, 64'hA5A5);
        tick();
        applyStimulus(1'b1, 64'h3C3C, waited);
        @(negedge clk);
        checkOutput("steer1_valid", bus.out1_valid, 1'b1);
        checkOutput("steer1_data", bus.out1_data, 64'h3C3C);
        tick();

        // Back-pressure on destination 0 must not block destination 1.
        bus.out0_ready = 1'b0;
        applyStimulus(1'b0, 64'hB001, waited);
        applyStimulus(1'b0, 64'hB002, waited);
        bus.in_valid  = 1'b1;
        bus.in_select = 1'b0;
        bus.in_data   = 64'hB003;
        @(negedge clk);
        checkOutput("iso_in_ready_low", bus.in_ready, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        applyStimulus(1'b1, 64'hC001, waited);
        checkOutput("iso_sel1_wait", waited, 1);
        drain();

        // Simultaneous push and pop keeps the count and advances the head.
        bus.out0_ready = 1'b0;
        applyStimulus(1'b0, 64'h1111, waited);
        bus.out0_ready = 1'b1;
        applyStimulus(1'b0, 64'h2222, waited);
        @(negedge clk);
        checkOutput("pp_count0", bus.out0_count, 1);
        checkOutput("pp_head0", bus.out0_data, 64'h2222);
        tick();
        drain();

        // Full FIFO refuses a push in the cycle it pops; accepted one cycle later.
        bus.out0_ready = 1'b0;
        applyStimulus(1'b0, 64'hF001, waited);
        applyStimulus(1'b0, 64'hF002, waited);
        bus.out0_ready = 1'b1;
        applyStimulus(1'b0, 64'hF003, waited);
        checkOutput("full_wait", waited, 2);
        drain();

        // Pointer wrap-around with a toggling consumer.
        readyMode      = 2;
        bus.out1_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, WIDTH'(i), waited);
        end
        drain();

        // Reset with beats buffered on both sides discards them.
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        applyStimulus(1'b0, 64'h0123_4567_89AB_CDEF, waited);
        applyStimulus(1'b1, 64'hFEDC_BA98_7654_3210, waited);
        applyStimulus(1'b1, 64'h5555_AAAA_5555_AAAA, waited);
        doReset();

        // Randomized traffic with random consumer back-pressure.
        readyMode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) tick();
            applyStimulus(1'($urandom_range(1)), {$urandom, $urandom}, waited);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
